det_track_ctl: RTL
==================

Name: det_track_ctl

Overview:
- Per-frame detection hysteresis controller; parametrised successor of the strobe/search controller.
- Consumes per-frame object-detect results and runs a 3-state machine: SEARCH, ACQUIRE, TRACK.
- Drives illuminator strobe enable (duty-skipped while searching), search-mode flag to the detector, and gesture-engine enable.
- Single clock domain; sits between the object detector and the strobe driver / gesture engine.

Parameters:
- CNT_W, 4, width of the hit, miss and skip counters.
- DET_THR, 4, consecutive hits to leave SEARCH; range 1..2^CNT_W-1.
- ENG_THR, 4, consecutive hits to reach TRACK; range DET_THR..2^CNT_W-1.
- UNDET_THR, 15, consecutive misses to fall back to SEARCH; range 1..2^CNT_W-1.
- SKIP_PERIOD, 10, frames strobe stays off after an unstrobed miss in SEARCH; 0 disables skipping; range 0..2^CNT_W-1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- i_obj_det  in  1  detect result; valid only when i_obj_det_trig=1
- i_obj_det_trig  in  1  one-cycle frame-result strobe
- i_force_search  in  1  synchronous abort to SEARCH
- i_hold  in  1  ignore triggers; freeze counters and state
- o_search_mode  out  1  1 while state==SEARCH
- o_en_strobe  out  1  illuminator strobe enable
- o_en_engine  out  1  gesture-engine enable, registered
- o_state  out  2  00=SEARCH, 01=ACQUIRE, 10=TRACK
- o_det_cnt  out  CNT_W  current consecutive-hit count

Behaviour:
- Reset values: state SEARCH; all counters 0; o_search_mode=1; o_en_engine=0; o_en_strobe=1; o_state=00; o_det_cnt=0.
- Update event: i_obj_det_trig=1, i_hold=0, i_force_search=0. All other cycles leave counters and state unchanged.
- Hit counter on update: a miss clears it. A hit increments it, saturating at 2^CNT_W-1.
- Miss counter on update: a hit clears it. A miss increments it, saturating at 2^CNT_W-1.
- Skip counter on update: a hit loads 0. A miss with skip==0 loads SKIP_PERIOD. A miss with skip!=0 decrements it. Counts only in SEARCH; forced to 0 in ACQUIRE and TRACK.
- State transitions are evaluated on the post-update counter values; state changes in the same cycle as the counters.
  - SEARCH: hit_next>=ENG_THR -> TRACK; else hit_next>=DET_THR -> ACQUIRE.
  - ACQUIRE: hit_next>=ENG_THR -> TRACK; miss_next>=UNDET_THR -> SEARCH.
  - TRACK: miss_next>=UNDET_THR -> SEARCH.
  - Misses below UNDET_THR hold the current state; no partial downgrade from TRACK to ACQUIRE.
- i_force_search=1: next cycle state=SEARCH and all counters=0. It has priority over the trigger and over i_hold.
- i_hold=1 with a trigger: the trigger is dropped, not queued.
- o_en_strobe is combinational: (skip==0) | (state!=SEARCH). With SKIP_PERIOD=0 it is constant 1.
- o_search_mode and o_state are decoded from the state register with no added latency.
- o_en_engine is the registered value of (state==TRACK): it rises and falls one clk after the state change.
- Latency: a trigger at cycle N gives the new state at N+1 and o_en_engine at N+2.
- Reset asserted mid-operation returns every output to its reset value immediately (asynchronous).
- Elaboration-time check: ENG_THR<DET_THR or any threshold >2^CNT_W-1 is a fatal error.

Optional Feature:
- Macro DET_TRACK_EVT_EN.
- Defined: adds outputs o_acq_evt and o_lost_evt, each 1 bit, registered, one-cycle pulses.
  - o_acq_evt pulses on entry to TRACK.
  - o_lost_evt pulses on any transition TRACK->SEARCH, including one caused by i_force_search.
  - Both reset to 0.
- Undefined: the ports are absent and the event logic is not built; all other behaviour is identical.

Decomposition:
- Shared package det_track_pkg holds the state encoding constants (ST_SEARCH, ST_ACQUIRE, ST_TRACK), the state width, and a parameter-range check function.
- One sub-module is natural: sat_cnt, a CNT_W saturating counter with clear and increment enables. It is instantiated twice, for hits and misses.
- The skip counter and the FSM stay in the top module.

Test Plan:
- Reset, then 4 hit triggers with defaults -> state 00->10 at the 4th trigger +1 clk; o_en_engine=1 one clk later; o_en_strobe stays 1 throughout.
- ENG_THR=8, 8 hits -> ACQUIRE after hit 4, TRACK after hit 8; a miss at hit 6 clears o_det_cnt to 0 and state stays 01.
- In TRACK, 14 misses -> still TRACK; 15th miss -> SEARCH, o_en_engine=0 two clk after the trigger.
- In SEARCH, misses with SKIP_PERIOD=10 -> o_en_strobe pattern: 1 until the 1st miss, then 0 for 10 triggers, then 1; a hit mid-skip forces o_en_strobe=1 at the next cycle.
- i_hold=1 with 5 hit triggers -> counters and state unchanged; i_force_search pulse in TRACK -> SEARCH and counters 0 next clk; o_lost_evt pulses when DET_TRACK_EVT_EN is defined.
- Assert reset mid-ACQUIRE, asynchronously between clk edges -> all outputs at reset values before the next edge.

Source files
------------

// File: rtl/det_track_pkg.sv
// Shared definitions for the detection hysteresis controller:
// the state encoding and a parameter legality check used at elaboration.
package det_track_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_SEARCH  = 2'b00,
        ST_ACQUIRE = 2'b01,
        ST_TRACK   = 2'b10
    } state_e;

    // True when every threshold fits the counter width and ENG_THR >= DET_THR.
    function automatic bit params_ok(input int cnt_w,
                                     input int det_thr,
                                     input int eng_thr,
                                     input int undet_thr,
                                     input int skip_period);
        int max_v;
        max_v = (32'sd1 <<< cnt_w) - 32'sd1;
        return (det_thr >= 32'sd1) && (det_thr <= max_v) &&
               (eng_thr >= det_thr) && (eng_thr <= max_v) &&
               (undet_thr >= 32'sd1) && (undet_thr <= max_v) &&
               (skip_period >= 32'sd0) && (skip_period <= max_v);
    endfunction

endpackage

// File: rtl/det_track_ctl_sat_cnt.sv
// sat_cnt: W-bit up counter with synchronous clear (priority) and an
// increment enable that stops at all-ones instead of wrapping.
module sat_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] MAX_V = {W{1'b1}};
    localparam logic [W-1:0] ONE_V = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise increment until saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {W{1'b0}};
        end else if (inc_i && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + ONE_V;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/det_track_ctl.sv
// det_track_ctl: per-frame detection hysteresis controller (SEARCH / ACQUIRE /
// TRACK). Drives strobe enable, detector search-mode flag and engine enable.
// Optional macro DET_TRACK_EVT_EN adds registered o_acq_evt / o_lost_evt pulses.
module det_track_ctl
    import det_track_pkg::*;
#(
    parameter int CNT_W       = 4,
    parameter int DET_THR     = 4,
    parameter int ENG_THR     = 4,
    parameter int UNDET_THR   = 15,
    parameter int SKIP_PERIOD = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_obj_det,
    input  logic             i_obj_det_trig,
    input  logic             i_force_search,
    input  logic             i_hold,
    output logic             o_search_mode,
    output logic             o_en_strobe,
    output logic             o_en_engine,
    output logic [ST_W-1:0]  o_state,
    output logic [CNT_W-1:0] o_det_cnt
`ifdef DET_TRACK_EVT_EN
    ,
    output logic             o_acq_evt,
    output logic             o_lost_evt
`endif
);

    if (!params_ok(CNT_W, DET_THR, ENG_THR, UNDET_THR, SKIP_PERIOD)) begin : g_bad_params
        $fatal(1, "det_track_ctl: illegal threshold/width parameter set");
    end

    // Thresholds are compared against count+1 in CNT_W+1 bits so that the
    // post-update value is known without waiting for the counter register.
    localparam logic [CNT_W:0]   DET_W   = (CNT_W+1)'(DET_THR);
    localparam logic [CNT_W:0]   ENG_W   = (CNT_W+1)'(ENG_THR);
    localparam logic [CNT_W:0]   UNDET_W = (CNT_W+1)'(UNDET_THR);
    localparam logic [CNT_W:0]   PLUS1_W = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] SKIP_V  = CNT_W'(SKIP_PERIOD);
    localparam logic [CNT_W-1:0] ONE_V   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ZERO_V  = {CNT_W{1'b0}};

    logic             upd_s;
    logic             hit_clr_s;
    logic             hit_inc_s;
    logic             miss_clr_s;
    logic             miss_inc_s;
    logic [CNT_W-1:0] hit_cnt_s;
    logic [CNT_W-1:0] miss_cnt_s;
    logic [CNT_W:0]   hit_plus_s;
    logic [CNT_W:0]   miss_plus_s;
    logic             hit_ge_det_s;
    logic             hit_ge_eng_s;
    logic             miss_ge_undet_s;

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] skip_q;
    logic [CNT_W-1:0] skip_d;
    logic             en_engine_q;

    // A frame result only counts when neither hold nor force-search is active.
    assign upd_s      = i_obj_det_trig & ~i_hold & ~i_force_search;
    assign hit_clr_s  = i_force_search | (upd_s & ~i_obj_det);
    assign hit_inc_s  = upd_s & i_obj_det;
    assign miss_clr_s = i_force_search | (upd_s & i_obj_det);
    assign miss_inc_s = upd_s & ~i_obj_det;

    sat_cnt #(.W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (hit_clr_s),
        .inc_i (hit_inc_s),
        .cnt_o (hit_cnt_s)
    );

    sat_cnt #(.W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (miss_clr_s),
        .inc_i (miss_inc_s),
        .cnt_o (miss_cnt_s)
    );

    // Saturation never matters here: every threshold is at most the max count.
    assign hit_plus_s      = {1'b0, hit_cnt_s} + PLUS1_W;
    assign miss_plus_s     = {1'b0, miss_cnt_s} + PLUS1_W;
    assign hit_ge_det_s    = hit_inc_s & (hit_plus_s >= DET_W);
    assign hit_ge_eng_s    = hit_inc_s & (hit_plus_s >= ENG_W);
    assign miss_ge_undet_s = miss_inc_s & (miss_plus_s >= UNDET_W);

    // Skip counter: only runs in SEARCH; reloads on an unstrobed miss at zero.
    always_comb begin
        skip_d = skip_q;
        if (i_force_search || (state_q != ST_SEARCH)) begin
            skip_d = ZERO_V;
        end else if (upd_s) begin
            if (i_obj_det) begin
                skip_d = ZERO_V;
            end else if (skip_q == ZERO_V) begin
                skip_d = SKIP_V;
            end else begin
                skip_d = skip_q - ONE_V;
            end
        end else begin
            skip_d = skip_q;
        end
    end

    // Next state from the post-update counts; misses never downgrade TRACK to ACQUIRE.
    always_comb begin
        state_d = state_q;
        if (i_force_search) begin
            state_d = ST_SEARCH;
        end else if (upd_s) begin
            case (state_q)
                ST_SEARCH: begin
                    if (hit_ge_eng_s) begin
                        state_d = ST_TRACK;
                    end else if (hit_ge_det_s) begin
                        state_d = ST_ACQUIRE;
                    end else begin
                        state_d = ST_SEARCH;
                    end
                end
                ST_ACQUIRE: begin
                    if (hit_ge_eng_s) begin
                        state_d = ST_TRACK;
                    end else if (miss_ge_undet_s) begin
                        state_d = ST_SEARCH;
                    end else begin
                        state_d = ST_ACQUIRE;
                    end
                end
                ST_TRACK: begin
                    if (miss_ge_undet_s) begin
                        state_d = ST_TRACK == ST_TRACK ? ST_SEARCH : ST_TRACK;
                    end else begin
                        state_d = ST_TRACK;
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State, skip count and delayed engine enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_SEARCH;
            skip_q      <= ZERO_V;
            en_engine_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            en_engine_q <= (state_q == ST_TRACK);
        end
    end

    assign o_state       = state_q;
    assign o_search_mode = (state_q == ST_SEARCH);
    assign o_en_strobe   = (skip_q == ZERO_V) | (state_q != ST_SEARCH);
    assign o_en_engine   = en_engine_q;
    assign o_det_cnt     = hit_cnt_s;

`ifdef DET_TRACK_EVT_EN
    logic acq_evt_q;
    logic lost_evt_q;

    // One-cycle pulses aligned with the new state becoming visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acq_evt_q  <= 1'b0;
            lost_evt_q <= 1'b0;
        end else begin
            acq_evt_q  <= (state_q != ST_TRACK) && (state_d == ST_TRACK);
            lost_evt_q <= (state_q == ST_TRACK) && (state_d == ST_SEARCH);
        end
    end

    assign o_acq_evt  = acq_evt_q;
    assign o_lost_evt = lost_evt_q;
`endif

endmodule
